// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with write-through read ports
// and an issue scoreboard that stalls RAW/WAW hazards.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              WB_Write,
  input  logic [ADDR_W-1:0] WB_Addr,
  input  logic [DATA_W-1:0] WB_Data,
  input  logic              issue_valid,
  input  logic              issue_has_dst,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              stall,
  output logic [NREG-1:0]   busy_mask,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [NREG-1:0]   clr_vec;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   pend_vec;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] dbg_val;
  logic              wb_we;
  logic              raw_a;
  logic              raw_b;
  logic              waw;
  logic              do_set;

  assign wb_we = WB_Write && (WB_Addr != '0);

  function automatic logic [DATA_W-1:0] rd_val(
    input logic [ADDR_W-1:0] a
  );
    logic              hit;
    logic [DATA_W-1:0] v;
    hit = wb_we && (WB_Addr == a);
    v   = '0;
    unique case (1'b1)
      (a == '0): v = '0;
      hit:       v = WB_Data;
      default:   v = regs[a];
    endcase
    return v;
  endfunction

  always_comb begin
    rs_val  = rd_val(rs_addr);
    rt_val  = rd_val(rt_addr);
    dbg_val = rd_val(dbg_addr);
  end

  // A same-cycle write-back frees its register: bypass covers it.
  always_comb begin
    clr_vec = '0;
    if (wb_we)
      clr_vec[WB_Addr] = 1'b1;
    pend_vec    = busy & ~clr_vec;
    pend_vec[0] = 1'b0;
  end

  always_comb begin
    raw_a = pend_vec[rs_addr];
    raw_b = pend_vec[rt_addr];
    waw   = issue_has_dst
         && pend_vec[issue_dst];
    stall = issue_valid
         && (raw_a || raw_b || waw);
  end

  always_comb begin
    do_set = issue_valid
          && issue_has_dst
          && (issue_dst != '0)
          && !stall;
    set_vec = '0;
    if (do_set)
      set_vec[issue_dst] = 1'b1;
  end

  // Set wins: the write-back belongs to an older instruction.
  always_comb begin
    busy_nxt    = (busy & ~clr_vec) | set_vec;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wb_we) begin
      regs[WB_Addr] <= WB_Data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_data <= '0;
      rt_data <= '0;
    end else if (rd_en) begin
      rs_data <= rs_val;
      rt_data <= rt_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dbg_data <= '0;
    else
      dbg_data <= dbg_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  assign busy_mask = busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed checks of reads, bypass,
// scoreboard stalls and asynchronous reset.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rd_en;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        WB_Write;
  logic [4:0]  WB_Addr;
  logic [31:0] WB_Data;
  logic        issue_valid;
  logic        issue_has_dst;
  logic [4:0]  issue_dst;
  logic        stall;
  logic [31:0] busy_mask;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int errors = 0;
  int checks = 0;

  reg_file_sb dut (
    .clk           (clk),
    .rst           (rst),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rd_en         (rd_en),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .WB_Write      (WB_Write),
    .WB_Addr       (WB_Addr),
    .WB_Data       (WB_Data),
    .issue_valid   (issue_valid),
    .issue_has_dst (issue_has_dst),
    .issue_dst     (issue_dst),
    .stall         (stall),
    .busy_mask     (busy_mask),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(
    input logic        w,
    input logic [4:0]  a,
    input logic [31:0] d
  );
    WB_Write = w;
    WB_Addr  = a;
    WB_Data  = d;
  endtask

  task automatic iss(
    input logic       v,
    input logic       h,
    input logic [4:0] d,
    input logic [4:0] s,
    input logic [4:0] t
  );
    issue_valid   = v;
    issue_has_dst = h;
    issue_dst     = d;
    rs_addr       = s;
    rt_addr       = t;
  endtask

  initial begin
    rst = 1'b1;
    rd_en = 1'b0;
    dbg_addr = '0;
    wb(1'b0, 5'd0, 32'h0);
    iss(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (2) tick();
    chk("rst_busy", busy_mask, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_dbg", dbg_data, 32'h0);
    rst = 1'b0;

    rs_addr = 5'd5;
    rt_addr = 5'd31;
    rd_en = 1'b1;
    tick();
    chk("rd0_rs", rs_data, 32'h0);
    chk("rd0_rt", rt_data, 32'h0);
    chk("rd0_busy", busy_mask, 32'h0);
    chk("rd0_stall", {31'b0, stall}, 32'h0);

    rd_en = 1'b0;
    wb(1'b1, 5'd7, 32'hDEADBEEF);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    rs_addr = 5'd7;
    dbg_addr = 5'd7;
    rd_en = 1'b1;
    tick();
    chk("wr7_rs", rs_data, 32'hDEADBEEF);
    chk("wr7_dbg", dbg_data, 32'hDEADBEEF);

    wb(1'b1, 5'd0, 32'h1234);
    rt_addr = 5'd0;
    dbg_addr = 5'd0;
    tick();
    chk("r0_byp_rt", rt_data, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("r0_rt", rt_data, 32'h0);
    chk("r0_dbg", dbg_data, 32'h0);

    wb(1'b1, 5'd9, 32'hA5A5A5A5);
    rs_addr = 5'd9;
    rt_addr = 5'd7;
    dbg_addr = 5'd9;
    tick();
    chk("byp_rs", rs_data, 32'hA5A5A5A5);
    chk("byp_rt", rt_data, 32'hDEADBEEF);
    chk("byp_dbg", dbg_data, 32'hA5A5A5A5);

    wb(1'b0, 5'd0, 32'h0);
    rd_en = 1'b0;
    rs_addr = 5'd0;
    tick();
    chk("hold_rs", rs_data, 32'hA5A5A5A5);

    iss(1'b1, 1'b1, 5'd3, 5'd1, 5'd2);
    #1;
    chk("iss3_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("iss3_busy", busy_mask, 32'h0000_0008);

    iss(1'b1, 1'b1, 5'd10, 5'd3, 5'd2);
    #1;
    chk("raw_a_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("raw_a_busy", busy_mask, 32'h0000_0008);

    wb(1'b1, 5'd3, 32'h33);
    #1;
    chk("raw_wb_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("raw_wb_busy", busy_mask, 32'h0000_0400);
    wb(1'b0, 5'd0, 32'h0);

    iss(1'b1, 1'b1, 5'd4, 5'd1, 5'd2);
    tick();
    chk("set4_busy", busy_mask, 32'h0000_0410);

    iss(1'b1, 1'b0, 5'd0, 5'd1, 5'd4);
    #1;
    chk("raw_b_stall", {31'b0, stall}, 32'h1);

    iss(1'b1, 1'b1, 5'd4, 5'd1, 5'd2);
    wb(1'b1, 5'd4, 32'h44);
    #1;
    chk("sbc_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("sbc_busy", busy_mask, 32'h0000_0410);
    wb(1'b0, 5'd0, 32'h0);

    iss(1'b1, 1'b1, 5'd0, 5'd1, 5'd2);
    tick();
    chk("dst0_busy", busy_mask, 32'h0000_0410);
    iss(1'b1, 1'b0, 5'd5, 5'd1, 5'd2);
    tick();
    chk("nodst_busy", busy_mask, 32'h0000_0410);

    iss(1'b1, 1'b1, 5'd6, 5'd0, 5'd0);
    rs_addr = 5'd9;
    rt_addr = 5'd7;
    rd_en = 1'b1;
    tick();
    chk("set6_busy", busy_mask, 32'h0000_0450);
    chk("pre_rs", rs_data, 32'hA5A5A5A5);

    iss(1'b1, 1'b1, 5'd6, 5'd0, 5'd0);
    #1;
    chk("waw_stall", {31'b0, stall}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy_mask, 32'h0);
    chk("arst_rs", rs_data, 32'h0);
    chk("arst_rt", rt_data, 32'h0);
    chk("arst_stall", {31'b0, stall}, 32'h0);
    tick();
    rst = 1'b0;
    iss(1'b0, 1'b0, 5'd0, 5'd7, 5'd9);
    tick();
    chk("post_rs", rs_data, 32'h0);
    chk("post_rt", rt_data, 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
